// File: rtl/wb_burst_ram.sv
// Wishbone B3 slave RAM: classic cycles plus registered-feedback incrementing bursts (linear/wrap4/8/16).
// Latency: first ack or err WAIT_STATES+1 cycles after cyc&stb (misses always 1), then one beat per cycle.
// Backpressure: stb low while in transfer holds the beat index; cyc low aborts to idle without any write.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i      cycle valid / strobe
//   wb_we_i, wb_sel_i       write enable, per-byte write selects
//   wb_adr_i, wb_dat_i      byte address (bits [1:0] ignored), write data
//   wb_cti_i, wb_bte_i      cycle type (000 classic, 010 incr burst, 111 end), burst type
//   wb_ack_o, wb_err_o      normal / error termination (never both)
//   wb_rty_o                retry, tied low
//   wb_dat_o                read data, zero outside the transfer state
// MEM_WORDS must be a power of two and at least 32 so every wrap length fits below the index MSB.
module wb_burst_ram #(
  parameter int              dw          = 32,
  parameter int              aw          = 32,
  parameter int              MEM_WORDS   = 4096,
  parameter logic [aw-1:0]   BASE_ADDR   = '0,
  parameter int              WAIT_STATES = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o,
  output logic [dw-1:0] wb_dat_o
);

  localparam int            IW  = $clog2(MEM_WORDS);
  localparam logic [2:0]    WS  = 3'(WAIT_STATES);
  localparam logic [IW-1:0] ONE = {{(IW-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  logic [1:0]    state;
  logic [2:0]    wcnt;
  logic [IW-1:0] idx;
  logic [2:0]    cti_q;
  logic [1:0]    bte_q;
  logic          ovf;       // linear burst has stepped past the last word

  logic [dw-1:0] mem [MEM_WORDS];
  logic [dw-1:0] ram_q;

  logic          req;
  logic          hit;
  logic [IW-1:0] adr_idx;
  logic          beat;
  logic          last;
  logic          wr_en;
  logic          advance;
  logic [IW-1:0] nxt_idx;
  logic          nxt_ovf;
  logic [IW-1:0] rd_idx;
  logic          unused_adr;

  assign req     = wb_cyc_i & wb_stb_i;
  // The window is aligned to its own size, so a hit is an upper-bit match.
  assign hit     = (wb_adr_i[aw-1:IW+2] == BASE_ADDR[aw-1:IW+2]);
  assign adr_idx = wb_adr_i[IW+1:2];
  assign unused_adr = ^wb_adr_i[1:0];

  assign beat     = (state == S_XFER) && req;
  assign wb_ack_o = beat && !ovf;
  assign wb_err_o = ((state == S_ERR) && req) || (beat && ovf);
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = ((state == S_XFER) && !ovf) ? ram_q : '0;

  // Anything other than an incrementing burst is treated as a single beat.
  assign last    = (cti_q != CTI_INCR) || (wb_cti_i == CTI_END);
  assign wr_en   = wb_ack_o && wb_we_i;
  assign advance = wb_ack_o && !last;

  // Wrap bursts only count in the low bits; linear bursts flag running off the end.
  always_comb begin
    nxt_idx = idx + ONE;
    nxt_ovf = 1'b0;
    case (bte_q)
      2'b01:   nxt_idx = {idx[IW-1:2], idx[1:0] + 2'd1};
      2'b10:   nxt_idx = {idx[IW-1:3], idx[2:0] + 3'd1};
      2'b11:   nxt_idx = {idx[IW-1:4], idx[3:0] + 4'd1};
      default: nxt_ovf = &idx;
    endcase
  end

  // The RAM is read every cycle: the request address while idle, the next beat
  // as soon as the current one is acked, otherwise the held beat.
  always_comb begin
    rd_idx = idx;
    if (state == S_IDLE) begin
      rd_idx = adr_idx;
    end else if (advance) begin
      rd_idx = nxt_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      wcnt  <= '0;
      idx   <= '0;
      cti_q <= '0;
      bte_q <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            if (!hit) begin
              state <= S_ERR;
            end else begin
              idx   <= adr_idx;
              cti_q <= wb_cti_i;
              bte_q <= wb_bte_i;
              ovf   <= 1'b0;
              wcnt  <= WS;
              state <= (WS != 3'd0) ? S_WAIT : S_XFER;
            end
          end
        end
        S_WAIT: begin
          if (!wb_cyc_i) begin
            wcnt  <= '0;
            state <= S_IDLE;
          end else if (wcnt <= 3'd1) begin
            wcnt  <= '0;
            state <= S_XFER;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        S_XFER: begin
          if (!wb_cyc_i) begin
            state <= S_IDLE;
          end else if (wb_stb_i) begin
            if (ovf || last) begin
              state <= S_IDLE;
            end else begin
              idx <= nxt_idx;
              ovf <= nxt_ovf;
            end
          end
        end
        default: begin
          if (!wb_cyc_i || wb_stb_i) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Write-first: a byte written this cycle at the word being read is forwarded.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < dw/8; b++) begin
      if (wr_en && wb_sel_i[b]) begin
        mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
      if (wr_en && wb_sel_i[b] && (idx == rd_idx)) begin
        ram_q[8*b +: 8] <= wb_dat_i[8*b +: 8];
      end else begin
        ram_q[8*b +: 8] <= mem[rd_idx][8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_ram.sv
module tb_wb_burst_ram;

  localparam int          MW   = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc0, cyc3, stb, we;
  logic [31:0] adr, dat_w;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack0, err0, rty0, ack3, err3, rty3;
  logic [31:0] dout0, dout3;

  int          total  = 0;
  int          passed = 0;
  logic [31:0] mdl [MW];
  logic [31:0] rdv;
  int          w, bsel, nbeat;
  logic        wr;

  always #5 clk = ~clk;

  wb_burst_ram #(.dw(32), .aw(32), .MEM_WORDS(MW), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_w), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0), .wb_dat_o(dout0));

  wb_burst_ram #(.dw(32), .aw(32), .MEM_WORDS(MW), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc3), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_w), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_ack_o(ack3), .wb_err_o(err3), .wb_rty_o(rty3), .wb_dat_o(dout3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    merge = o;
    for (int b = 0; b < 4; b++) if (s[b]) merge[8*b +: 8] = n[8*b +: 8];
  endfunction

  // Word touched by beat k of a burst starting at word s; linear bursts may exceed MW-1.
  function automatic int exp_idx(input int s, input logic [1:0] b, input int k);
    int len;
    if (b == 2'b00) return s + k;
    len = 2 << b;
    return (s / len) * len + ((s % len) + k) % len;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; cti = 3'b000; bte = 2'b00;
  endtask

  // Classic cycle; the bus is held one cycle past the ack to prove a single pulse.
  task automatic classic(input bit use3, input logic wr_i, input int wi, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] rd);
    int   ws;
    logic ak;
    ws = use3 ? 3 : 0;
    rd = '0;
    cyc0 = !use3; cyc3 = use3; stb = 1'b1; we = wr_i;
    adr = BASE + 32'(wi * 4); sel = s; dat_w = d; cti = 3'b000; bte = 2'b00;
    for (int c = 0; c <= ws + 2; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      ak = use3 ? ack3 : ack0;
      if (c == ws + 1) begin
        chk($sformatf("classic w%0d ack", wi), ak, 1'b1);
        chk($sformatf("classic w%0d err", wi), use3 ? err3 : err0, 1'b0);
        rd = use3 ? dout3 : dout0;
      end else begin
        chk($sformatf("classic w%0d ack cyc%0d", wi, c), ak, 1'b0);
      end
    end
    next_cycle();
    idle_bus();
    next_cycle();
    if (wr_i && !use3) mdl[wi] = merge(mdl[wi], d, s);
  endtask

  // Incrementing burst on dut0 with an optional run of stb-low cycles after beat gap_at.
  task automatic burst(input logic wr_i, input int s, input logic [1:0] b, input int n,
                       input int gap_at, input int gap_len, input string tag);
    logic [31:0] d [16];
    int          k, gaps, idx;
    bit          done, exp_err, on;
    for (int i = 0; i < 16; i++) d[i] = $urandom;
    k = 0; gaps = 0; done = 1'b0;
    cyc0 = 1'b1; stb = 1'b1; we = wr_i; adr = BASE + 32'(s * 4); sel = 4'hF;
    cti = (n == 1) ? 3'b111 : 3'b010; bte = b; dat_w = d[0];
    @(negedge clk);
    chk({tag, " ack in request cycle"}, ack0, 1'b0);
    for (int c = 1; c < n + gap_len + 2 && !done; c++) begin
      next_cycle();
      on = !(k == gap_at && gaps < gap_len);
      stb = on; adr = $urandom; dat_w = d[k];
      cti = (k == n - 1) ? 3'b111 : 3'b010;
      @(negedge clk);
      chk({tag, " ack/err exclusive"}, {31'b0, ack0 & err0}, 32'd0);
      if (!on) begin
        gaps++;
        chk($sformatf("%s gap ack c%0d", tag, c), ack0, 1'b0);
      end else begin
        idx = exp_idx(s, b, k);
        exp_err = (idx >= MW);
        chk($sformatf("%s beat%0d ack", tag, k), ack0, !exp_err);
        chk($sformatf("%s beat%0d err", tag, k), err0, exp_err);
        if (exp_err) begin
          done = 1'b1;
        end else begin
          if (!wr_i) chk($sformatf("%s beat%0d data", tag, k), dout0, mdl[idx]);
          else mdl[idx] = d[k];
          k++;
          if (k == n) done = 1'b1;
        end
      end
    end
    chk({tag, " completed"}, {31'b0, done}, 32'd1);
    next_cycle();
    stb = 1'b1; cti = 3'b000; adr = BASE + 32'(s * 4);
    @(negedge clk);
    chk({tag, " ack after end"}, ack0, 1'b0);
    chk({tag, " err after end"}, err0, 1'b0);
    next_cycle();
    idle_bus();
    next_cycle();
  endtask

  initial begin
    idle_bus();
    adr = '0; dat_w = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset ack0", ack0, 1'b0);
    chk("reset err0", err0, 1'b0);
    chk("reset rty0", rty0, 1'b0);
    chk("reset dat0", dout0, 32'd0);
    chk("reset ack3", ack3, 1'b0);
    chk("reset dat3", dout3, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Pre-fill: word i holds i.
    for (int i = 0; i < MW; i++) classic(1'b0, 1'b1, i, 4'hF, 32'(i), rdv);

    // Wrap4 read from word 6: 6,7,4,5, cti=111 on the fourth beat.
    burst(1'b0, 6, 2'b01, 4, 99, 0, "wrap4");

    // Byte-select write merge.
    classic(1'b0, 1'b1, 4, 4'hF, 32'h1111_1111, rdv);
    classic(1'b0, 1'b1, 4, 4'b0101, 32'hDEAD_BEEF, rdv);
    classic(1'b0, 1'b0, 4, 4'hF, 32'h0, rdv);
    chk("sel merge data", rdv, 32'h11AD_11EF);

    // Linear write burst running off the end of the array.
    burst(1'b1, MW - 2, 2'b00, 3, 99, 0, "edge_wr");
    classic(1'b0, 1'b0, MW - 2, 4'hF, 32'h0, rdv);
    chk("edge word MW-2", rdv, mdl[MW - 2]);
    classic(1'b0, 1'b0, MW - 1, 4'hF, 32'h0, rdv);
    chk("edge word MW-1", rdv, mdl[MW - 1]);
    classic(1'b0, 1'b0, 0, 4'hF, 32'h0, rdv);
    chk("edge word 0 untouched", rdv, 32'd0);

    // Out-of-window accesses just above and just below the window.
    for (int m = 0; m < 2; m++) begin
      cyc0 = 1'b1; stb = 1'b1; we = (m == 1); sel = 4'hF; cti = 3'b000;
      adr = (m == 0) ? BASE + 32'(4 * MW) : BASE - 32'd4;
      @(negedge clk);
      chk($sformatf("miss%0d err T", m), err0, 1'b0);
      next_cycle();
      @(negedge clk);
      chk($sformatf("miss%0d err T+1", m), err0, 1'b1);
      chk($sformatf("miss%0d ack T+1", m), ack0, 1'b0);
      chk($sformatf("miss%0d dat T+1", m), dout0, 32'd0);
      next_cycle();
      @(negedge clk);
      chk($sformatf("miss%0d err T+2", m), err0, 1'b0);
      next_cycle();
      idle_bus();
      next_cycle();
    end

    // 8-beat linear read with two master wait cycles after beat 2.
    burst(1'b0, 10, 2'b00, 8, 2, 2, "lin8_gap");

    // Wait-state instance: ack exactly at T+4.
    classic(1'b1, 1'b1, 5, 4'hF, 32'hCAFE_F00D, rdv);
    classic(1'b1, 1'b0, 5, 4'hF, 32'h0, rdv);
    chk("ws3 read data", rdv, 32'hCAFE_F00D);

    // Randomized classic traffic against the array model.
    for (int i = 0; i < 30; i++) begin
      w  = $urandom_range(0, MW - 1);
      wr = 1'($urandom_range(0, 1));
      if (wr) begin
        classic(1'b0, 1'b1, w, 4'($urandom_range(1, 15)), $urandom, rdv);
      end else begin
        classic(1'b0, 1'b0, w, 4'hF, 32'h0, rdv);
        chk($sformatf("rand read w%0d", w), rdv, mdl[w]);
      end
    end

    // Randomized wrap and linear bursts.
    for (int i = 0; i < 6; i++) begin
      bsel = $urandom_range(1, 3);
      burst(1'($urandom_range(0, 1)), $urandom_range(0, MW - 1), 2'(bsel), 2 << bsel,
            $urandom_range(1, 3), $urandom_range(0, 2), $sformatf("rwrap%0d", i));
      nbeat = $urandom_range(2, 8);
      burst(1'($urandom_range(0, 1)), $urandom_range(0, MW - nbeat), 2'b00, nbeat,
            $urandom_range(1, 3), $urandom_range(0, 2), $sformatf("rlin%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      w = $urandom_range(0, MW - 1);
      classic(1'b0, 1'b0, w, 4'hF, 32'h0, rdv);
      chk($sformatf("post-burst read w%0d", w), rdv, mdl[w]);
    end

    // Reset asserted during beat 2 of a write burst.
    cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'(20 * 4); sel = 4'hF;
    cti = 3'b010; bte = 2'b00; dat_w = 32'hA5A5_0001;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk("rst burst beat1 ack", ack0, 1'b1);
    mdl[20] = 32'hA5A5_0001;
    next_cycle();
    dat_w = 32'h5A5A_0002;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst mid-burst ack", ack0, 1'b0);
    chk("rst mid-burst err", err0, 1'b0);
    chk("rst mid-burst rty", rty0, 1'b0);
    chk("rst mid-burst dat", dout0, 32'd0);
    next_cycle();
    rst = 1'b0;
    idle_bus();
    next_cycle();
    classic(1'b0, 1'b0, 21, 4'hF, 32'h0, rdv);
    chk("rst beat2 word unchanged", rdv, mdl[21]);
    classic(1'b0, 1'b0, 20, 4'hF, 32'h0, rdv);
    chk("rst beat1 word written", rdv, 32'hA5A5_0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
